// File: rtl/store_buffer_if.sv
// Pipeline-side and dcache-side signals of the store buffer, grouped so the
// buffer and its environment share one bundle; the buffer takes the slave side.
`ifndef CPU_INST_BITS
`define CPU_INST_BITS 32
`endif
`ifndef CPU_ADDR_BITS
`define CPU_ADDR_BITS 32
`endif
`ifndef CPU_DATA_BITS
`define CPU_DATA_BITS 32
`endif

interface store_buffer_if #(
    parameter int DEPTH = 4
);
    logic                          st_valid;
    logic                          st_ready;
    logic [`CPU_INST_BITS-1:0]     inst_MEM;
    logic [`CPU_ADDR_BITS-1:0]     addr_MEM;
    logic [`CPU_DATA_BITS-1:0]     rs2_MEM;
    logic                          st_fault;
    logic                          dcache_req;
    logic [`CPU_ADDR_BITS-1:0]     dcache_addr;
    logic [`CPU_DATA_BITS-1:0]     dcache_din;
    logic [3:0]                    dcache_we;
    logic                          dcache_ack;
    logic [`CPU_ADDR_BITS-1:0]     ld_addr;
    logic                          ld_conflict;
    logic [$clog2(DEPTH):0]        count;
    logic                          empty;

    modport slave (
        input  st_valid, inst_MEM, addr_MEM, rs2_MEM, dcache_ack, ld_addr,
        output st_ready, st_fault, dcache_req, dcache_addr, dcache_din,
               dcache_we, ld_conflict, count, empty
    );

    modport master (
        output st_valid, inst_MEM, addr_MEM, rs2_MEM, dcache_ack, ld_addr,
        input  st_ready, st_fault, dcache_req, dcache_addr, dcache_din,
               dcache_we, ld_conflict, count, empty
    );
endinterface

// File: rtl/store_buffer.sv
// Store buffer: formats MEM-stage stores into word-aligned dcache writes,
// queues them in a small FIFO, drains over req/ack and flags load hazards.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave sb
);
    localparam int PW = $clog2(DEPTH);

    logic [29:0]       addr_mem [DEPTH];
    logic [31:0]       din_mem  [DEPTH];
    logic [3:0]        we_mem   [DEPTH];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW:0]       count_q, count_d;
    logic              fault_q, fault_d;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              is_store;
    logic              legal;
    logic [31:0]       fmt_din;
    logic [3:0]        fmt_we;
    logic              enq;
    logic              deq;
    logic              empty;
    logic              hit;
    logic [PW-1:0]     rel;
    logic              unused_bits;

    assign opcode   = sb.inst_MEM[6:0];
    assign funct3   = sb.inst_MEM[14:12];
    assign is_store = (opcode == 7'b0100011);

    always_comb begin
        legal   = 1'b0;
        fmt_din = '0;
        fmt_we  = '0;
        case (funct3)
            3'b000: begin
                legal   = 1'b1;
                fmt_din = {4{sb.rs2_MEM[7:0]}};
                fmt_we  = 4'b0001 << sb.addr_MEM[1:0];
            end
            3'b001: begin
                legal   = ~sb.addr_MEM[0];
                fmt_din = {2{sb.rs2_MEM[15:0]}};
                fmt_we  = sb.addr_MEM[1] ? 4'b1100 : 4'b0011;
            end
            3'b010: begin
                legal   = (sb.addr_MEM[1:0] == 2'b00);
                fmt_din = sb.rs2_MEM;
                fmt_we  = 4'b1111;
            end
            default: legal = 1'b0;
        endcase
    end

    assign empty   = (count_q == '0);
    assign sb.st_ready = (count_q != (PW+1)'(DEPTH));
    assign enq     = sb.st_valid & sb.st_ready & is_store & legal;
    assign deq     = ~empty & sb.dcache_ack;
    assign fault_d = sb.st_valid & is_store & ~legal;

    always_comb begin
        wr_ptr_d = enq ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = deq ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fault_q  <= fault_d;
        end
    end

    // Payload storage carries no reset; validity comes only from the pointers.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[wr_ptr_q] <= sb.addr_MEM[31:2];
            din_mem[wr_ptr_q]  <= fmt_din;
            we_mem[wr_ptr_q]   <= fmt_we;
        end
    end

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        hit = 1'b0;
        rel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel = PW'(i) - rd_ptr_q;
            if (({1'b0, rel} < count_q) && (addr_mem[i] == sb.ld_addr[31:2]))
                hit = 1'b1;
        end
    end

    assign sb.ld_conflict = hit;
    assign sb.st_fault    = fault_q;
    assign sb.count       = count_q;
    assign sb.empty       = empty;
    assign sb.dcache_req  = ~empty;
    assign sb.dcache_addr = empty ? '0 : {addr_mem[rd_ptr_q], 2'b00};
    assign sb.dcache_din  = empty ? '0 : din_mem[rd_ptr_q];
    assign sb.dcache_we   = empty ? '0 : we_mem[rd_ptr_q];

    assign unused_bits = ^{sb.inst_MEM[31:15], sb.inst_MEM[11:7], sb.ld_addr[1:0]};
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: a queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    bit   run_cmp;

    store_buffer_if #(.DEPTH(DEPTH)) sb ();

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  w;
    } ent_t;

    ent_t q[$];
    logic fault_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte-lane view of a store: an access of sz bytes occupies lanes
    // off..off+sz-1 of its word, and every lane carries byte (lane mod sz).
    function automatic void fmt(input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] d, output bit ok,
                                output logic [31:0] din, output logic [3:0] we);
        int sz;
        int off;
        sz  = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        off = int'(a % 4);
        ok  = (f3 <= 3'd2) && (a % sz == 0);
        din = '0;
        we  = '0;
        for (int b = 0; b < 4; b++) begin
            din[8*b +: 8] = d[8*(b % sz) +: 8];
            if (b >= off && b < off + sz) we[b] = 1'b1;
        end
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            fault_exp <= 1'b0;
        end else begin
            bit          ok;
            bit          is_st;
            bit          room;
            logic [31:0] din;
            logic [3:0]  we;
            ent_t        e;
            is_st = (sb.inst_MEM[6:0] == 7'b0100011);
            fmt(sb.inst_MEM[14:12], sb.addr_MEM, sb.rs2_MEM, ok, din, we);
            room = (q.size() < DEPTH);
            fault_exp <= sb.st_valid && is_st && !ok;
            if (sb.dcache_ack && q.size() > 0) void'(q.pop_front());
            if (sb.st_valid && is_st && ok && room) begin
                e.a = {sb.addr_MEM[31:2], 2'b00};
                e.d = din;
                e.w = we;
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            bit ldc;
            ldc = 1'b0;
            foreach (q[i]) if (q[i].a[31:2] == sb.ld_addr[31:2]) ldc = 1'b1;
            chk("req",      32'(sb.dcache_req), 32'(q.size() != 0));
            chk("count",    32'(sb.count), 32'(q.size()));
            chk("empty",    32'(sb.empty), 32'(q.size() == 0));
            chk("st_ready", 32'(sb.st_ready), 32'(q.size() < DEPTH));
            chk("st_fault", 32'(sb.st_fault), 32'(fault_exp));
            chk("ld_conf",  32'(sb.ld_conflict), 32'(ldc));
            if (q.size() != 0) begin
                chk("d_addr", sb.dcache_addr, q[0].a);
                chk("d_din",  sb.dcache_din,  q[0].d);
                chk("d_we",   32'(sb.dcache_we), 32'(q[0].w));
            end else begin
                chk("d_addr0", sb.dcache_addr, 32'h0);
                chk("d_din0",  sb.dcache_din,  32'h0);
                chk("d_we0",   32'(sb.dcache_we), 32'h0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        sb.st_valid = 1'b1;
        sb.inst_MEM = {17'b0, f3, 5'b0, 7'b0100011};
        sb.addr_MEM = a;
        sb.rs2_MEM  = d;
        step();
        sb.st_valid = 1'b0;
    endtask

    task automatic ack_n(input int n);
        sb.dcache_ack = 1'b1;
        repeat (n) step();
        sb.dcache_ack = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        run_cmp = 1'b0;
        reset = 1'b0;
        sb.st_valid = 1'b0;
        sb.inst_MEM = '0;
        sb.addr_MEM = '0;
        sb.rs2_MEM = '0;
        sb.dcache_ack = 1'b0;
        sb.ld_addr = '0;
        repeat (3) step();
        run_cmp = 1'b1;
        @(negedge clk);
        chk("rst_req",   32'(sb.dcache_req), 32'h0);
        chk("rst_count", 32'(sb.count), 32'h0);
        step();
        reset = 1'b1;
        step();

        // SB to the top byte lane
        store(3'b000, 32'h0000_1003, 32'hAABB_CCDD);
        @(negedge clk);
        chk("sb_req",  32'(sb.dcache_req), 32'h1);
        chk("sb_addr", sb.dcache_addr, 32'h0000_1000);
        chk("sb_din",  sb.dcache_din, 32'hDDDD_DDDD);
        chk("sb_we",   32'(sb.dcache_we), 32'h8);
        step();
        ack_n(1);
        @(negedge clk);
        chk("sb_empty", 32'(sb.empty), 32'h1);
        step();

        // SH upper half, then SW
        store(3'b001, 32'h0000_2002, 32'h1234_5678);
        @(negedge clk);
        chk("sh_din", sb.dcache_din, 32'h5678_5678);
        chk("sh_we",  32'(sb.dcache_we), 32'hC);
        step();
        ack_n(1);
        store(3'b010, 32'h0000_2004, 32'hCAFE_F00D);
        @(negedge clk);
        chk("sw_din", sb.dcache_din, 32'hCAFE_F00D);
        chk("sw_we",  32'(sb.dcache_we), 32'hF);
        step();
        ack_n(1);

        // Illegal stores and a non-store opcode
        store(3'b001, 32'h0000_2001, 32'h1111_2222);
        @(negedge clk);
        chk("mis_fault", 32'(sb.st_fault), 32'h1);
        chk("mis_count", 32'(sb.count), 32'h0);
        step();
        @(negedge clk);
        chk("mis_fault_off", 32'(sb.st_fault), 32'h0);
        step();
        store(3'b011, 32'h0000_2000, 32'h3333_4444);
        @(negedge clk);
        chk("f3_fault", 32'(sb.st_fault), 32'h1);
        chk("f3_count", 32'(sb.count), 32'h0);
        step();
        sb.st_valid = 1'b1;
        sb.inst_MEM = 32'h0000_2003;
        step();
        sb.st_valid = 1'b0;
        @(negedge clk);
        chk("nonst_fault", 32'(sb.st_fault), 32'h0);
        chk("nonst_count", 32'(sb.count), 32'h0);
        step();

        // Fill, reject overflow, drain in order across the pointer wrap
        for (int i = 0; i < DEPTH; i++)
            store(3'b010, 32'h0000_4000 + 32'(4*i), 32'h1111_1111 * 32'(i+1));
        @(negedge clk);
        chk("full_ready", 32'(sb.st_ready), 32'h0);
        step();
        store(3'b010, 32'h0000_4100, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("full_count", 32'(sb.count), 32'(DEPTH));
        step();
        sb.dcache_ack = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk("drain_din",  sb.dcache_din, 32'h1111_1111 * 32'(i+1));
            chk("drain_addr", sb.dcache_addr, 32'h0000_4000 + 32'(4*i));
            step();
        end
        sb.dcache_ack = 1'b0;
        @(negedge clk);
        chk("drain_empty", 32'(sb.empty), 32'h1);
        step();

        // Full buffer with store and ack together
        for (int i = 0; i < DEPTH; i++)
            store(3'b000, 32'h0000_5000 + 32'(i), 32'h0000_00A0 + 32'(i));
        sb.dcache_ack = 1'b1;
        store(3'b010, 32'h0000_5100, 32'h7777_7777);
        sb.dcache_ack = 1'b0;
        @(negedge clk);
        chk("fa_count", 32'(sb.count), 32'(DEPTH-1));
        chk("fa_din",   sb.dcache_din, 32'hA1A1_A1A1);
        chk("fa_we",    32'(sb.dcache_we), 32'h2);
        step();
        ack_n(DEPTH-1);

        // Load hazard detection
        store(3'b010, 32'h0000_3008, 32'h0BAD_CAFE);
        sb.ld_addr = 32'h0000_300B;
        #1;
        chk("ld_hit", 32'(sb.ld_conflict), 32'h1);
        sb.ld_addr = 32'h0000_300C;
        #1;
        chk("ld_miss", 32'(sb.ld_conflict), 32'h0);
        sb.ld_addr = 32'h0000_300B;
        ack_n(1);
        @(negedge clk);
        chk("ld_after_ack", 32'(sb.ld_conflict), 32'h0);
        step();

        // Reset with entries pending
        for (int i = 0; i < 3; i++)
            store(3'b010, 32'h0000_6000 + 32'(4*i), 32'h6666_0000 + 32'(i));
        reset = 1'b0;
        #1;
        chk("rst_mid_req",   32'(sb.dcache_req), 32'h0);
        chk("rst_mid_count", 32'(sb.count), 32'h0);
        sb.dcache_ack = 1'b1;
        step();
        reset = 1'b1;
        repeat (3) step();
        sb.dcache_ack = 1'b0;
        @(negedge clk);
        chk("post_rst_req", 32'(sb.dcache_req), 32'h0);
        step();

        run_cmp = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
